// File: rtl/cpu_core_pkg.sv
// Shared definitions for cpu_core: bus encodings, MIPS opcode/funct
// constants, FSM states and ALU operation codes.
package cpu_core_pkg;

  localparam int MEM_ACCESS_BITS = 2;
  localparam int MEM_LEN_BITS    = 2;

  // Bus access type (MEM_ACCESS).
  typedef enum logic [MEM_ACCESS_BITS-1:0] {
    ACC_NONE = 2'd0,
    ACC_R    = 2'd1,
    ACC_W    = 2'd2,
    ACC_X    = 2'd3
  } mem_access_e;

  // Bus access length (MEM_LEN).
  typedef enum logic [MEM_LEN_BITS-1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2
  } mem_len_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core. Flags feed the branch comparators:
// zero/sign of (a - b) or of (a - 0).
module cpu_alu
  import cpu_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        zero,
  output logic        sign
);

  // Operation select
  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  result = {b[15:0], 16'b0};
      default:  result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
  assign sign = result[31];

endmodule

// File: rtl/mmu.sv
// Address translation stub reserved for future use; no ports, no logic.
module mmu;
endmodule

// File: rtl/cpu_core.sv
// Multi-cycle MIPS-I subset core, FETCH/DECODE/EXEC/MEM/WB, single shared
// bus port, branch delay slot via pc/npc pair.
// Optional: define CPU_TRACE_EN to print a line per retired instruction.
module cpu_core
  import cpu_core_pkg::*;
(
  input  logic                       clk,
  input  logic                       res,
  input  logic                       ready,
  input  logic [31:0]                db_dataIn,
  output logic [31:0]                db_dataOut,
  output logic [31:0]                db_addr,
  input  logic                       db_ready,
  output logic [MEM_ACCESS_BITS-1:0] db_accessType,
  output logic [MEM_LEN_BITS-1:0]    db_memLen
);

  state_e      state, state_nxt;
  logic [31:0] pc, npc, ir, a_q, b_q;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rd, sh;
  logic [31:0] imm_sext, imm_zext;

  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero, alu_sign;

  logic        wb_en, link, is_load, is_store, load_signed, taken;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val, target, load_val, store_data, rs_val, rt_val;
  mem_len_e    mem_len;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir[31:26];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sh       = ir[10:6];
  assign funct    = ir[5:0];
  assign imm_sext = sext16(ir[15:0]);
  assign imm_zext = {16'b0, ir[15:0]};

  mmu u_mmu ();

  cpu_alu u_alu (
    .a      (a_q),
    .b      (alu_b),
    .shamt  (alu_shamt),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .sign   (alu_sign)
  );

  // State register; ready low freezes the FSM
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all registers update together from pre-edge values.
    if (res)        state <= S_FETCH;
    else if (ready) state <= state_nxt;
  end

  // Next-state logic; bus states wait for db_ready
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (db_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (is_load || is_store) ? S_MEM : S_FETCH;
      S_MEM:    if (db_ready) state_nxt = is_load ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Bus outputs; one request per FETCH/MEM, forced idle in reset or when frozen
  always_comb begin
    db_accessType = ACC_NONE;
    db_addr       = pc;
    db_dataOut    = '0;
    db_memLen     = LEN_W;
    case (state)
      S_FETCH: db_accessType = ACC_X;
      S_MEM: begin
        db_accessType = is_store ? ACC_W : ACC_R;
        db_addr       = alu_result;
        db_memLen     = mem_len;
        db_dataOut    = store_data;
      end
      default: ;
    endcase
    if (res) begin
      db_accessType = ACC_NONE;
      db_addr       = '0;
      db_dataOut    = '0;
      db_memLen     = LEN_W;
    end else if (!ready) begin
      db_accessType = ACC_NONE;
    end
  end

  // Instruction decode: ALU controls, writeback target, memory attributes
  always_comb begin
    alu_op      = ALU_ADD;
    alu_b       = b_q;
    alu_shamt   = sh;
    wb_en       = 1'b0;
    wb_reg      = rt;
    link        = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    load_signed = 1'b0;
    mem_len     = LEN_W;
    case (opcode)
      OP_SPECIAL: begin
        wb_en  = 1'b1;
        wb_reg = rd;
        case (funct)
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: begin alu_op = ALU_SLL; alu_shamt = a_q[4:0]; end
          FN_SRLV: begin alu_op = ALU_SRL; alu_shamt = a_q[4:0]; end
          FN_SRAV: begin alu_op = ALU_SRA; alu_shamt = a_q[4:0]; end
          FN_JR:   wb_en = 1'b0;
          FN_JALR: link = 1'b1;
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: wb_en = 1'b0;
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ: begin alu_op = ALU_SUB; alu_b = '0; end
      OP_BEQ, OP_BNE:  alu_op = ALU_SUB;
      OP_JAL:          begin wb_en = 1'b1; wb_reg = 5'd31; link = 1'b1; end
      OP_ADDI, OP_ADDIU: begin wb_en = 1'b1; alu_b = imm_sext; end
      OP_SLTI:   begin wb_en = 1'b1; alu_op = ALU_SLT;  alu_b = imm_sext; end
      OP_SLTIU:  begin wb_en = 1'b1; alu_op = ALU_SLTU; alu_b = imm_sext; end
      OP_ANDI:   begin wb_en = 1'b1; alu_op = ALU_AND;  alu_b = imm_zext; end
      OP_ORI:    begin wb_en = 1'b1; alu_op = ALU_OR;   alu_b = imm_zext; end
      OP_XORI:   begin wb_en = 1'b1; alu_op = ALU_XOR;  alu_b = imm_zext; end
      OP_LUI:    begin wb_en = 1'b1; alu_op = ALU_LUI;  alu_b = imm_zext; end
      OP_LB:     begin is_load = 1'b1; alu_b = imm_sext; mem_len = LEN_B; load_signed = 1'b1; end
      OP_LBU:    begin is_load = 1'b1; alu_b = imm_sext; mem_len = LEN_B; end
      OP_LH:     begin is_load = 1'b1; alu_b = imm_sext; mem_len = LEN_H; load_signed = 1'b1; end
      OP_LHU:    begin is_load = 1'b1; alu_b = imm_sext; mem_len = LEN_H; end
      OP_LW:     begin is_load = 1'b1; alu_b = imm_sext; end
      OP_SB:     begin is_store = 1'b1; alu_b = imm_sext; mem_len = LEN_B; end
      OP_SH:     begin is_store = 1'b1; alu_b = imm_sext; mem_len = LEN_H; end
      OP_SW:     begin is_store = 1'b1; alu_b = imm_sext; end
      default: ;
    endcase
  end

  // Branch/jump resolution from ALU flags; target relative to the delay slot
  always_comb begin
    taken  = 1'b0;
    target = npc + (imm_sext << 2);
    case (opcode)
      OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) begin
        taken  = 1'b1;
        target = a_q;
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      taken = alu_sign;
        else if (rt == RT_BGEZ) taken = !alu_sign;
      end
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = {npc[31:28], ir[25:0], 2'b00};
      end
      OP_BEQ:  taken = alu_zero;
      OP_BNE:  taken = !alu_zero;
      OP_BLEZ: taken = alu_sign || alu_zero;
      OP_BGTZ: taken = !alu_sign && !alu_zero;
      default: ;
    endcase
  end

  // Load extension, store alignment and writeback selection
  always_comb begin
    case (mem_len)
      LEN_B:   load_val = load_signed ? {{24{db_dataIn[7]}}, db_dataIn[7:0]}
                                      : {24'b0, db_dataIn[7:0]};
      LEN_H:   load_val = load_signed ? {{16{db_dataIn[15]}}, db_dataIn[15:0]}
                                      : {16'b0, db_dataIn[15:0]};
      default: load_val = db_dataIn;
    endcase
    case (mem_len)
      LEN_B:   store_data = {24'b0, b_q[7:0]};
      LEN_H:   store_data = {16'b0, b_q[15:0]};
      default: store_data = b_q;
    endcase
    wb_val   = link ? (pc + 32'd8) : alu_result;
    rf_we    = 1'b0;
    rf_waddr = wb_reg;
    rf_wdata = wb_val;
    if (state == S_EXEC && wb_en) begin
      rf_we = 1'b1;
    end else if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
      rf_wdata = load_val;
    end
  end

  // Register read ports, addressed straight from the fetched word during DECODE
  assign rs_val = (db_dataIn[25:21] == 5'd0) ? 32'd0 : rf[db_dataIn[25:21]];
  assign rt_val = (db_dataIn[20:16] == 5'd0) ? 32'd0 : rf[db_dataIn[20:16]];

  // Register file write; $0 is never written
  always_ff @(posedge clk) begin
    // NOTE: the register file is an explicit flop array so it can be cleared on reset.
    if (res) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (ready && rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // Datapath registers: IR and operands in DECODE, pc/npc advance in EXEC
  always_ff @(posedge clk) begin
    if (res) begin
      pc  <= '0;
      npc <= 32'd4;
      ir  <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (ready) begin
      if (state == S_DECODE) begin
        ir  <= db_dataIn;
        a_q <= rs_val;
        b_q <= rt_val;
      end
      if (state == S_EXEC) begin
        pc  <= npc;
        npc <= taken ? target : npc + 32'd4;
      end
    end
  end

`ifdef CPU_TRACE_EN
  logic [31:0] ir_pc;

  // Remember the address of the instruction in flight
  always_ff @(posedge clk) begin
    if (res)                           ir_pc <= '0;
    else if (ready && state == S_DECODE) ir_pc <= pc;
  end

  // Print one line per retired instruction
  always_ff @(posedge clk) begin
    if (!res && ready) begin
      if ((state == S_EXEC && !is_load && !is_store) || state == S_WB) begin
        if (rf_we && rf_waddr != 5'd0)
          $display("trace pc=%h ir=%h r%0d=%h", ir_pc, ir, rf_waddr, rf_wdata);
        else
          $display("trace pc=%h ir=%h", ir_pc, ir);
      end else if (state == S_MEM && is_store && db_ready) begin
        $display("trace pc=%h ir=%h", ir_pc, ir);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: big-endian byte memory model with write log
// and fetch timestamps, one program covering ALU, console store, loads,
// branch delay slot, jal link and a ready stall during a store.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        res, ready, db_ready;
  logic [31:0] db_dataIn, db_dataOut, db_addr;
  logic [1:0]  db_accessType, db_memLen;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk           (clk),
    .res           (res),
    .ready         (ready),
    .db_dataIn     (db_dataIn),
    .db_dataOut    (db_dataOut),
    .db_addr       (db_addr),
    .db_ready      (db_ready),
    .db_accessType (db_accessType),
    .db_memLen     (db_memLen)
  );

  // Memory model state
  logic [7:0]  mem [4096];
  logic [31:0] rdata = '0;
  int          cyc = 0;
  int          fcyc [1024];
  logic        fetched [1024];
  logic [31:0] wlog_addr [32];
  logic [31:0] wlog_data [32];
  logic [1:0]  wlog_len  [32];
  int          w_cnt = 0;
  logic        marker_seen = 1'b0;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_word;

  assign db_dataIn = rdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) begin
      mem[ld_addr]         <= ld_word[31:24];
      mem[ld_addr + 12'd1] <= ld_word[23:16];
      mem[ld_addr + 12'd2] <= ld_word[15:8];
      mem[ld_addr + 12'd3] <= ld_word[7:0];
      fetched[ld_addr[11:2]] <= 1'b0;
    end else if (db_ready && db_accessType != 2'd0) begin
      if (db_accessType == 2'd2) begin
        if (w_cnt < 32) begin
          wlog_addr[w_cnt] <= db_addr;
          wlog_data[w_cnt] <= db_dataOut;
          wlog_len[w_cnt]  <= db_memLen;
        end
        w_cnt <= w_cnt + 1;
        if (db_addr == 32'h3fc) marker_seen <= 1'b1;
        if (db_addr[31:12] == 20'd0) begin
          case (db_memLen)
            2'd0: mem[db_addr[11:0]] <= db_dataOut[7:0];
            2'd1: begin
              mem[db_addr[11:0]]         <= db_dataOut[15:8];
              mem[db_addr[11:0] + 12'd1] <= db_dataOut[7:0];
            end
            default: begin
              mem[db_addr[11:0]]         <= db_dataOut[31:24];
              mem[db_addr[11:0] + 12'd1] <= db_dataOut[23:16];
              mem[db_addr[11:0] + 12'd2] <= db_dataOut[15:8];
              mem[db_addr[11:0] + 12'd3] <= db_dataOut[7:0];
            end
          endcase
        end
      end else begin
        case (db_memLen)
          2'd0: rdata <= {24'b0, mem[db_addr[11:0]]};
          2'd1: rdata <= {16'b0, mem[db_addr[11:0]], mem[db_addr[11:0] + 12'd1]};
          default: rdata <= {mem[db_addr[11:0]], mem[db_addr[11:0] + 12'd1],
                             mem[db_addr[11:0] + 12'd2], mem[db_addr[11:0] + 12'd3]};
        endcase
        if (db_accessType == 2'd3) begin
          fcyc[db_addr[11:2]]    <= cyc;
          fetched[db_addr[11:2]] <= 1'b1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] word);
    ld_en   = 1'b1;
    ld_addr = addr[11:0];
    ld_word = word;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  logic [31:0] prog [34];
  logic [31:0] exp_addr [13];
  logic [31:0] exp_data [13];
  logic [31:0] exp_mask [13];
  logic [1:0]  exp_len  [13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic stalled;
    int   n104;
    stalled = 1'b0;
    prog = '{
      32'h24010005, 32'h00211021, 32'hAC020100, 32'h3C03A000,  // 00..0C
      32'h34630001, 32'h24040041, 32'hA0640000, 32'h80060200,  // 10..1C
      32'h90070200, 32'h8C080204, 32'hAC060300, 32'hAC070304,  // 20..2C
      32'hAC080308, 32'h10000002, 32'h24050001, 32'h24050007,  // 30..3C
      32'hAC05030C, 32'h2409FFFD, 32'h00095043, 32'h0029582B,  // 40..4C
      32'h0029602A, 32'hAC0A0310, 32'hAC0B0314, 32'hAC0C0318,  // 50..5C
      32'h0C00001C, 32'h240D0009, 32'h00000000, 32'h00000000,  // 60..6C
      32'hAC1F031C, 32'hAC0D0320, 32'hAC010104, 32'hAC0003FC,  // 70..7C
      32'h08000020, 32'h00000000                               // 80..84
    };
    exp_addr = '{32'h100, 32'hA0000001, 32'h300, 32'h304, 32'h308, 32'h30C, 32'h310,
                 32'h314, 32'h318, 32'h31C, 32'h320, 32'h104, 32'h3FC};
    exp_data = '{32'h0000000A, 32'h00000041, 32'hFFFFFF80, 32'h00000080, 32'h12345678,
                 32'h1, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h68, 32'h9, 32'h5, 32'h0};
    exp_mask = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exp_len  = '{2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

    res = 1'b1; ready = 1'b1; db_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_word = '0;
    @(negedge clk); @(negedge clk);
    check("rst_type", {30'b0, db_accessType}, 32'd0);
    check("rst_addr", db_addr, 32'd0);
    check("rst_dout", db_dataOut, 32'd0);
    check("rst_len",  {30'b0, db_memLen}, 32'd2);

    for (int i = 0; i < 34; i++) poke(i * 4, prog[i]);
    poke(32'h200, 32'h80000000);
    poke(32'h204, 32'h12345678);

    res = 1'b0;
    #1;
    check("first_type", {30'b0, db_accessType}, 32'd3);
    check("first_addr", db_addr, 32'd0);
    check("first_len",  {30'b0, db_memLen}, 32'd2);

    for (int n = 0; n < 3000 && !marker_seen; n++) begin
      @(negedge clk);
      if (!stalled && db_accessType == 2'd2 && db_addr == 32'h104) begin
        stalled = 1'b1;
        ready   = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1 check("stall_idle", {30'b0, db_accessType}, 32'd0);
          @(negedge clk);
        end
        ready = 1'b1;
      end
    end
    check("timeout", {31'b0, marker_seen}, 32'd1);
    repeat (20) @(negedge clk);

    check("stall_hit", {31'b0, stalled}, 32'd1);
    check("w_count", w_cnt, 32'd13);
    n104 = 0;
    for (int i = 0; i < 13 && i < w_cnt; i++) begin
      if (wlog_addr[i] == 32'h104) n104++;
      check($sformatf("w%0d_addr", i), wlog_addr[i], exp_addr[i]);
      check($sformatf("w%0d_len", i), {30'b0, wlog_len[i]}, {30'b0, exp_len[i]});
      check($sformatf("w%0d_data", i), wlog_data[i] & exp_mask[i], exp_data[i]);
    end
    check("stall_store_once", n104, 32'd1);

    check("lat_addiu",  fcyc[1]  - fcyc[0],  32'd3);
    check("lat_sw",     fcyc[3]  - fcyc[2],  32'd4);
    check("lat_lb",     fcyc[8]  - fcyc[7],  32'd5);
    check("lat_beq",    fcyc[14] - fcyc[13], 32'd3);
    check("lat_slot",   fcyc[16] - fcyc[14], 32'd3);
    check("lat_stall",  fcyc[31] - fcyc[30], 32'd7);
    check("skip_3c",    {31'b0, fetched[15]}, 32'd0);
    check("fetch_40",   {31'b0, fetched[16]}, 32'd1);
    check("skip_68",    {31'b0, fetched[26]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
